pixel_write_port: RTL

//  Responder end of the datapath's pixel-plot interface (x, y, colour, plot) for the 160x120 screen.

---
 rtl/pixel_pkg.sv | 18 +
 rtl/pixel_write_port_fifo.sv | 51 +++++
 rtl/pixel_write_port.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared constants and types for the pixel-plot write path.
package pixel_pkg;

  localparam int unsigned SCREEN_W   = 160;
  localparam int unsigned SCREEN_H   = 120;
  localparam int unsigned PIX_ADDR_W = 15;
  localparam int unsigned COLOUR_W   = 3;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } state_e;

endpackage

// File: rtl/pixel_write_port_fifo.sv
// Small synchronous FIFO; power-of-two depth with wrap-bit pointers.
module pixel_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign rdata_c = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    do_push  = push && !full_c;
    do_pop   = pop && !empty_c;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/pixel_write_port.sv
// Pixel-plot responder: range check, linear address, plot FIFO, and full-screen clear.
module pixel_write_port
  import pixel_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = PIX_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                plot,
  output logic                ready,
  output logic                dropped,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we
);

  localparam int unsigned ENTRY_W   = ADDR_W + COLOUR_W;
  localparam logic [7:0]  X_LIM     = 8'(SCREEN_W);
  localparam logic [6:0]  Y_LIM     = 7'(SCREEN_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [COLOUR_W-1:0] fill_colour_q, fill_colour_d;
  logic                clear_busy_q, clear_busy_d;
  logic                dropped_q, dropped_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [COLOUR_W-1:0] mem_data_q, mem_data_d;

  logic                in_range, accept, fifo_push, fifo_pop;
  logic                fifo_full, fifo_empty;
  logic [ADDR_W-1:0]   plot_addr;
  logic [ENTRY_W-1:0]  rd_entry;

  // y*160 + x as two shifts; busy gating keeps ready low through the final fill write.
  assign plot_addr = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  assign in_range  = (x < X_LIM) && (y < Y_LIM);
  assign ready     = !reset && !fifo_full && (state_q == IDLE) && !clear_busy_q && !clear_req;
  assign accept    = plot && ready;
  assign fifo_push = accept && in_range;

  pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wdata   ({plot_addr, colour}),
    .pop     (fifo_pop),
    .rdata_c (rd_entry),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fill_colour_d = fill_colour_q;
    clear_busy_d  = clear_busy_q;
    dropped_d     = accept && !in_range;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    fifo_pop      = 1'b0;

    if (!fifo_empty) begin
      fifo_pop   = 1'b1;
      mem_we_d   = 1'b1;
      mem_addr_d = rd_entry[ENTRY_W-1:COLOUR_W];
      mem_data_d = rd_entry[COLOUR_W-1:0];
    end

    unique case (state_q)
      IDLE: begin
        clear_busy_d = 1'b0;
        if (clear_req && !clear_busy_q) begin
          state_d       = DRAIN;
          fill_colour_d = clear_colour;
          clear_busy_d  = 1'b1;
        end
      end
      DRAIN: begin
        clear_busy_d = 1'b1;
        if (fifo_empty) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        clear_busy_d = 1'b1;
        mem_we_d     = 1'b1;
        mem_addr_d   = cnt_q;
        mem_data_d   = fill_colour_q;
        if (cnt_q == LAST_ADDR) state_d = IDLE;
        else                    cnt_d   = cnt_q + ADDR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      fill_colour_q <= '0;
      clear_busy_q  <= 1'b0;
      dropped_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fill_colour_q <= fill_colour_d;
      clear_busy_q  <= clear_busy_d;
      dropped_q     <= dropped_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
    end
  end

  assign clear_busy = clear_busy_q;
  assign dropped    = dropped_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;

endmodule
